hack_alu_arbiter: RTL
=====================

// Module: hack_alu_arbiter
// PURPOSE
//  Shares one hack_alu between NUM_REQ requesters (fetch/execute/debug ports).
//  Round-robin arbitration, operands and 6-bit control word captured into
//  registers, result and flags registered and returned on one response
//  channel tagged with the requester id. One operation in flight at a time.
// PARAMETERS
//  NUM_REQ  2  number of requesters, 2..4
//  ID_W     1  requester id width; 2**ID_W >= NUM_REQ
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   NUM_REQ     request pending, one bit per requester
//  req_ready  out  NUM_REQ     one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
//  req_x      in   16*NUM_REQ  x operand, requester i at [16*i+15:16*i]
//  req_y      in   16*NUM_REQ  y operand, same packing
//  req_ctrl   in   6*NUM_REQ   {zx,nx,zy,ny,f,no}, requester i at [6*i+5:6*i]
//  rsp_valid  out  1           result available
//  rsp_ready  in   1           consumer takes result
//  rsp_id     out  ID_W        index of requester that owns the result
//  rsp_out    out  16          ALU result
//  rsp_zr     out  1           result == 0
//  rsp_ng     out  1           result[15]
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zr=0,
//    rsp_ng=0, operand/ctrl regs=0, last_grant=NUM_REQ-1 (req 0 wins first).
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: scan last_grant+1, +2, ... mod NUM_REQ; first valid requester g gets
//      req_ready[g]=1 (combinational, only in IDLE); on that edge capture
//      x/y/ctrl/id of g, last_grant<=g, go EXEC. No valid: stay IDLE, req_ready=0.
//    EXEC: hack_alu driven from captured regs only; at edge register out/zr/ng
//      into rsp_*, rsp_valid<=1, go RESP.
//    RESP: rsp_* held stable while rsp_valid & !rsp_ready; on rsp_valid &
//      rsp_ready: rsp_valid<=0, go IDLE. rsp_out/zr/ng/id keep last values.
//  - req_ready=0 in EXEC and RESP; requesters must hold request stable until accepted.
//  - Latency: accept at edge T -> rsp_valid high after edge T+1 (2 cycles).
//    Throughput: 1 op per 3 cycles with rsp_ready held high.
//  - Arithmetic: 16-bit two's complement, carry discarded (0x7FFF+1 = 0x8000, ng=1).
//  - req_valid deasserted before grant: dropped, no effect on last_grant.
//  - Requester index >= NUM_REQ never granted; NUM_REQ=1 illegal.
//  - rst mid-EXEC/RESP: in-flight op discarded, no response ever produced.
// STRUCTURE
//  - Shared header hack_alu_defs.vh: ctrl encodings CTRL_ZERO=101010,
//    CTRL_ONE=111111, CTRL_NEG1=111010, CTRL_X=001100, CTRL_Y=110000,
//    CTRL_XPLUSY=000010, CTRL_XMINUSY=010011, CTRL_YMINUSX=000111,
//    CTRL_XANDY=000000, CTRL_XORY=010101; FSM state codes.
//  - One sub-module: hack_alu instance (u_alu); round-robin picker and FSM inline.
// TESTING
//  1. Reset with req_valid=11 -> all outputs 0, busy=0; after release req_ready=01.
//  2. Req0 x=5 y=3 ctrl=000010 at T -> rsp_valid after T+1, rsp_out=8, zr=0, ng=0, id=0.
//  3. Both requesters valid continuously, rsp_ready=1 -> grant order 0,1,0,1,...; ids match.
//  4. x=3 y=5 ctrl=010011 -> rsp_out=0xFFFE, ng=1; ctrl=101010 -> rsp_out=0, zr=1;
//     x=0x7FFF y=1 ctrl=000010 -> 0x8000, ng=1.
//  5. rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0; accepted on first rsp_ready=1.
//  6. rst pulsed during EXEC -> rsp_valid never rises; after release req0 and req1 valid -> req0 granted.

Source files
------------

// File: rtl/hack_alu_arbiter_pkg.sv
// hack_alu_arbiter_pkg: ALU control encodings, control-word layout and FSM states
package hack_alu_arbiter_pkg;
   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;
   localparam logic [5:0] CTRL_ZERO    = 6'b101010;
   localparam logic [5:0] CTRL_ONE     = 6'b111111;
   localparam logic [5:0] CTRL_NEG1    = 6'b111010;
   localparam logic [5:0] CTRL_X       = 6'b001100;
   localparam logic [5:0] CTRL_Y       = 6'b110000;
   localparam logic [5:0] CTRL_XPLUSY  = 6'b000010;
   localparam logic [5:0] CTRL_XMINUSY = 6'b010011;
   localparam logic [5:0] CTRL_YMINUSX = 6'b000111;
   localparam logic [5:0] CTRL_XANDY   = 6'b000000;
   localparam logic [5:0] CTRL_XORY    = 6'b010101;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/hack_alu_arbiter_if.sv
// hack_alu_arbiter_if: packed request lanes plus the shared tagged response channel
interface hack_alu_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_x;
   logic [16*NUM_REQ-1:0] req_y;
   logic [6*NUM_REQ-1:0]  req_ctrl;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [15:0]           rsp_out;
   logic                  rsp_zr;
   logic                  rsp_ng;
   logic                  busy;
   modport master (
      output req_valid, req_x, req_y, req_ctrl, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng, busy
   );
   modport slave (
      input  req_valid, req_x, req_y, req_ctrl, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng, busy
   );
endinterface

// File: rtl/hack_alu_arbiter_alu.sv
// hack_alu: combinational Hack ALU with zero/negate preprocessing and zr/ng flags
module hack_alu
   import hack_alu_arbiter_pkg::*;
(
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  alu_ctrl_t   ctrl,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);
   logic [15:0] xz, yz, xa, ya, fo;
   assign xz  = ctrl.zx ? 16'h0 : x;
   assign yz  = ctrl.zy ? 16'h0 : y;
   assign xa  = ctrl.nx ? ~xz : xz;
   assign ya  = ctrl.ny ? ~yz : yz;
   assign fo  = ctrl.f ? xa + ya : xa & ya;
   assign out = ctrl.no ? ~fo : fo;
   assign zr  = out == 16'h0;
   assign ng  = out[15];
endmodule

// File: rtl/hack_alu_arbiter.sv
// hack_alu_arbiter: round-robin sharing of one hack_alu, one operation in flight,
// registered result returned with the owning requester id.
module hack_alu_arbiter
   import hack_alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input logic               clk,
   input logic               rst,
   hack_alu_arbiter_if.slave bus
);
   state_t          state, state_nxt;
   logic [ID_W-1:0] last_grant, pick, id_r;
   logic            pick_valid;
   logic [15:0]     sel_x, sel_y, x_r, y_r, alu_out;
   logic [5:0]      sel_ctrl;
   alu_ctrl_t       ctrl_r;
   logic            alu_zr, alu_ng;
   // Scan starts just past the last winner, so the previous owner has lowest priority
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      sel_x      = '0;
      sel_y      = '0;
      sel_ctrl   = '0;
      for (int k = 1; k <= NUM_REQ; k++)
         for (int i = 0; i < NUM_REQ; i++)
            if (!pick_valid && i == (int'(last_grant) + k) % NUM_REQ && bus.req_valid[i]) begin
               pick_valid = 1'b1;
               pick       = ID_W'(i);
               sel_x      = bus.req_x[16*i +: 16];
               sel_y      = bus.req_y[16*i +: 16];
               sel_ctrl   = bus.req_ctrl[6*i +: 6];
            end
   end
   assign bus.req_ready = (state == IDLE && pick_valid && !rst) ? NUM_REQ'(1) << pick : '0;
   assign bus.rsp_valid = state == RESP;
   assign bus.busy      = state != IDLE;
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE && pick_valid)    ? EXEC :
                  (state == EXEC)                  ? RESP :
                  (state == RESP && bus.rsp_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         last_grant  <= ID_W'(NUM_REQ - 1);
         id_r        <= '0;
         x_r         <= '0;
         y_r         <= '0;
         ctrl_r      <= '0;
         bus.rsp_id  <= '0;
         bus.rsp_out <= '0;
         bus.rsp_zr  <= 1'b0;
         bus.rsp_ng  <= 1'b0;
      end else if (state == IDLE && pick_valid) begin
         last_grant <= pick;
         id_r       <= pick;
         x_r        <= sel_x;
         y_r        <= sel_y;
         ctrl_r     <= alu_ctrl_t'(sel_ctrl);
      end else if (state == EXEC) begin
         bus.rsp_id  <= id_r;
         bus.rsp_out <= alu_out;
         bus.rsp_zr  <= alu_zr;
         bus.rsp_ng  <= alu_ng;
      end
   hack_alu u_alu (
      .x   (x_r),
      .y   (y_r),
      .ctrl(ctrl_r),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );
endmodule
